wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-unit results onto the single register-file write port.
// One-cycle latency to wen/waddr/wdata; lu_ready drops when the FIFO is full; pipe_hold stalls upstream on starvation.
module wb_arbiter #(
  parameter int DSIZE        = 32,
  parameter int ASIZE        = 5,
  parameter int NREG         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_valid,
  input  logic [ASIZE-1:0] pipe_rd,
  input  logic [DSIZE-1:0] pipe_data,
  output logic             pipe_hold,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [ASIZE-1:0] lu_rd,
  input  logic [DSIZE-1:0] lu_data,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic [NREG-1:0]  pend_mask
);

  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGW-1:0]  AGE_MAX  = AGW'(STARVE_LIMIT);
  localparam logic [AGW-1:0]  AGE_HOLD = AGW'(STARVE_LIMIT - 1);
  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  typedef struct packed {
    logic [ASIZE-1:0] rd;
    logic [DSIZE-1:0] data;
  } ent_t;

  // Entries are kept compacted: slot 0 is the head, valid slots are contiguous.
  ent_t             ent     [DEPTH];
  ent_t             ent_nxt [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [AGW-1:0]   age;
  logic [AGW-1:0]   age_nxt;
  logic             hold_nxt;
  logic             empty;
  logic             lu_xfer;
  logic             pipe_elig;
  logic             pop;
  logic             bypass;
  logic             enq;
  logic             head_kill;
  logic             grant;
  logic             placed;
  ent_t             wr_sel;

  assign empty     = ~vld[0];
  assign lu_ready  = ~vld[DEPTH-1];
  assign lu_xfer   = lu_valid & lu_ready;
  assign pipe_elig = pipe_valid & (pipe_rd != '0) & ~pipe_hold;
  assign pop       = ~empty & ~pipe_elig;
  assign bypass    = empty & ~pipe_elig & lu_xfer & (lu_rd != '0);
  // Long-unit results are older than the concurrent pipe result, so a matching rd is stale.
  assign enq       = lu_xfer & (lu_rd != '0) & ~bypass & ~(pipe_elig & (lu_rd == pipe_rd));
  assign head_kill = vld[0] & pipe_elig & (ent[0].rd == pipe_rd);
  assign grant     = pipe_elig | pop | bypass;
  assign hold_nxt  = (age == AGE_HOLD) & ~empty & ~pop & ~head_kill;

  always_comb begin
    wr_sel.rd   = lu_rd;
    wr_sel.data = lu_data;
    if (pipe_elig) begin
      wr_sel.rd   = pipe_rd;
      wr_sel.data = pipe_data;
    end else if (pop) begin
      wr_sel = ent[0];
    end
  end

  // Remove popped/killed entries from the top down so lower indices stay valid, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_nxt[i] = ent[i];
    vld_nxt = vld;
    placed  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && ((pop && i == 0) || (pipe_elig && ent[i].rd == pipe_rd))) begin
        for (int k = i; k < DEPTH - 1; k++) begin
          ent_nxt[k] = ent_nxt[k+1];
          vld_nxt[k] = vld_nxt[k+1];
        end
        vld_nxt[DEPTH-1] = 1'b0;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (enq && !placed && !vld_nxt[k]) begin
        ent_nxt[k].rd   = lu_rd;
        ent_nxt[k].data = lu_data;
        vld_nxt[k]      = 1'b1;
        placed          = 1'b1;
      end
    end
  end

  always_comb begin
    age_nxt = age;
    if (empty || pop || head_kill) age_nxt = '0;
    else if (age != AGE_MAX)       age_nxt = age + 1'b1;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend_mask = pend_mask | (ONE_HOT0 << ent[i].rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      age       <= '0;
      pipe_hold <= 1'b0;
      wen       <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      vld       <= vld_nxt;
      age       <= age_nxt;
      pipe_hold <= hold_nxt;
      wen       <= grant;
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      if (grant) begin
        waddr <= wr_sel.rd;
        wdata <= wr_sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: bypass, queueing, starvation hold, WAW kill, x0 filtering, async reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;

  int total = 0;
  int bad   = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_hold(pipe_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  task automatic wr(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, wen, e);
    if (e) begin
      chk({tag, "_waddr"}, waddr, a);
      chk({tag, "_wdata"}, wdata, d);
    end
  endtask

  // x0 must never be written
  always @(negedge clk) begin
    if (!rst && wen) chk("x0_write", waddr != 5'd0, 1'b1);
  end

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0);
    lu(0, 0, 0);
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", pipe_hold, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_ready", lu_ready, 1);
    step();
    step();
    rst = 1'b0;

    // plain pipe write, then rd=0 suppressed
    pipe(1, 5, 32'h1234);
    step();
    wr("pipe5", 1, 5, 32'h1234);
    pipe(1, 0, 32'h5555);
    step();
    chk("pipe0_wen", wen, 0);
    chk("pipe0_waddr_held", waddr, 5);
    chk("pipe0_wdata_held", wdata, 32'h1234);

    // bypass into empty FIFO
    pipe(0, 0, 0);
    lu(1, 7, 32'hAA);
    step();
    wr("bypass7", 1, 7, 32'hAA);
    chk("bypass_pend", pend_mask, 0);

    // queue two entries behind continuous pipe writes, then starve
    pipe(1, 3, 32'h33);
    lu(1, 8, 32'h88);
    step();
    wr("q_a", 1, 3, 32'h33);
    chk("q_a_pend", pend_mask, 32'h100);
    chk("q_a_ready", lu_ready, 1);
    pipe(1, 3, 32'h34);
    lu(1, 9, 32'h99);
    step();
    wr("q_b", 1, 3, 32'h34);
    chk("q_b_pend", pend_mask, 32'h300);
    chk("q_b_ready", lu_ready, 0);
    lu(0, 0, 0);
    pipe(1, 3, 32'h35);
    step();
    wr("q_c", 1, 3, 32'h35);
    chk("q_c_hold", pipe_hold, 0);
    pipe(1, 3, 32'h36);
    step();
    chk("q_d_hold", pipe_hold, 0);
    pipe(1, 3, 32'h37);
    step();
    wr("q_e", 1, 3, 32'h37);
    chk("q_e_hold", pipe_hold, 1);
    pipe(1, 3, 32'h38);
    step();
    wr("starve8", 1, 8, 32'h88);
    chk("starve_hold_off", pipe_hold, 0);
    chk("starve_pend", pend_mask, 32'h200);
    chk("starve_ready", lu_ready, 1);
    pipe(0, 0, 0);
    step();
    wr("drain9", 1, 9, 32'h99);
    chk("drain_pend", pend_mask, 0);

    // WAW kill of a queued entry
    pipe(1, 2, 32'h20);
    lu(1, 4, 32'h11);
    step();
    wr("waw_setup", 1, 2, 32'h20);
    chk("waw_setup_pend", pend_mask, 32'h10);
    pipe(1, 4, 32'h22);
    lu(0, 0, 0);
    step();
    wr("waw_kill", 1, 4, 32'h22);
    chk("waw_kill_pend", pend_mask, 0);
    pipe(0, 0, 0);
    step();
    chk("waw_no_stale", wen, 0);

    // WAW kill of a same-cycle long-unit transfer
    pipe(1, 6, 32'h66);
    lu(1, 6, 32'h60);
    step();
    wr("waw_same", 1, 6, 32'h66);
    chk("waw_same_pend", pend_mask, 0);
    pipe(0, 0, 0);
    lu(0, 0, 0);
    step();
    chk("waw_same_no_stale", wen, 0);

    // push+pop at count=1, then rd=0 discards
    pipe(1, 1, 32'h01);
    lu(1, 10, 32'hA0);
    step();
    wr("pp_setup", 1, 1, 32'h01);
    chk("pp_setup_pend", pend_mask, 32'h400);
    pipe(0, 0, 0);
    lu(1, 11, 32'hB0);
    step();
    wr("pp_pop10", 1, 10, 32'hA0);
    chk("pp_pend11", pend_mask, 32'h800);
    lu(1, 0, 32'hDEAD);
    step();
    wr("pp_pop11", 1, 11, 32'hB0);
    chk("pp_pend_empty", pend_mask, 0);
    lu(1, 0, 32'hBEEF);
    step();
    chk("lu_rd0_no_bypass", wen, 0);
    chk("lu_rd0_pend", pend_mask, 0);

    // async reset mid-cycle with two entries queued
    pipe(1, 3, 32'h77);
    lu(1, 12, 32'hC0);
    step();
    wr("rq_a", 1, 3, 32'h77);
    pipe(1, 3, 32'h78);
    lu(1, 13, 32'hD0);
    step();
    chk("rq_pend", pend_mask, 32'h3000);
    chk("rq_ready", lu_ready, 0);
    pipe(0, 0, 0);
    lu(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wen", wen, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_hold", pipe_hold, 0);
    chk("arst_pend", pend_mask, 0);
    chk("arst_ready", lu_ready, 1);
    rst = 1'b0;
    step();
    chk("arst_lost", wen, 0);
    chk("arst_lost_pend", pend_mask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
